// File: rtl/fetch_pkg.sv
// fetch_pkg: flush codes, bubble word and fetch FSM states shared by IF, IF/ID and hazard logic
package fetch_pkg;
  localparam logic [1:0] FLUSH_NONE   = 2'b00;
  localparam logic [1:0] FLUSH_BRANCH = 2'b01;
  localparam logic [1:0] FLUSH_JUMP   = 2'b10;
  localparam logic [1:0] FLUSH_BUBBLE = 2'b11;
  localparam logic [31:0] NOP_INST = 32'hFC00_0000;
  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} fetch_state_e;
endpackage

// File: rtl/fetch_unit_pc_select.sv
// pc_select: redirect detection, target/code selection (jump beats branch) and sequential PC
module pc_select
  import fetch_pkg::*;
#(
  parameter logic [31:0] PC_STEP = 32'd4
) (
  input  logic [31:0] pc,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        redirect,
  output logic [31:0] target,
  output logic [1:0]  code,
  output logic [31:0] pc_seq
);
  always_comb begin
    redirect = !freeze && (jump || branch_taken);
    target   = jump ? jump_target : branch_target;
    code     = jump ? FLUSH_JUMP : FLUSH_BRANCH;
    pc_seq   = pc + PC_STEP;
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, runs the imem request/ready handshake, applies ID redirects
// and holds a returned word while the pipeline is frozen
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic [1:0]  flush
);
  fetch_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, req_addr_q, req_addr_d, hold_q, hold_d;
  logic        redirect;
  logic [31:0] target, pc_seq;
  logic [1:0]  code, flush_base;
  pc_select #(.PC_STEP(PC_STEP)) u_pc_select (
    .pc(pc_q), .freeze(freeze), .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .redirect(redirect), .target(target),
    .code(code), .pc_seq(pc_seq)
  );
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    hold_d      = hold_q;
    imem_req    = 1'b0;
    imem_addr   = pc_q;
    instruction = NOP_INST;
    pc_out      = pc_seq;
    flush_base  = FLUSH_BUBBLE;
    case (state_q)
      FETCH: begin
        imem_req    = 1'b1;
        instruction = imem_ready ? imem_rdata : NOP_INST;
        flush_base  = imem_ready ? FLUSH_NONE : FLUSH_BUBBLE;
        if (redirect) begin
          pc_d = target;
          if (!imem_ready) begin
            req_addr_d = pc_q;
            state_d    = DISCARD;
          end
        end else if (imem_ready) begin
          if (freeze) begin
            hold_d  = imem_rdata;
            state_d = HOLD;
          end else pc_d = pc_seq;
        end
      end
      HOLD: begin
        instruction = hold_q;
        flush_base  = FLUSH_NONE;
        if (!freeze) begin
          pc_d    = redirect ? target : pc_seq;
          state_d = FETCH;
        end
      end
      DISCARD: begin
        // memory cannot cancel, so keep the stale address up until it completes
        imem_req  = 1'b1;
        imem_addr = req_addr_q;
        pc_d      = redirect ? target : pc_q;
        state_d   = imem_ready ? FETCH : DISCARD;
      end
      default: state_d = FETCH;
    endcase
    flush = redirect ? code : flush_base;
    if (rst) begin
      imem_req    = 1'b0;
      instruction = NOP_INST;
      pc_out      = 32'd0;
      flush       = FLUSH_BUBBLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      hold_q     <= NOP_INST;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      hold_q     <= hold_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random stimulus, expected responses queued from a queue-based fetch model
module tb_fetch_unit;
  import fetch_pkg::*;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  logic clk = 1'b0, rst = 1'b0, freeze = 1'b0, branch_taken = 1'b0, jump = 1'b0, imem_ready = 1'b0;
  logic [31:0] branch_target = '0, jump_target = '0, imem_rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr, instruction, pc_out;
  logic [1:0]  flush;
  always #5 clk = ~clk;
  fetch_unit #(.RESET_PC(RST_PC), .PC_STEP(32'd4)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .instruction(instruction), .pc_out(pc_out), .flush(flush)
  );
  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pcout;
    logic [1:0]  flush;
  } exp_t;
  exp_t exp_q[$];
  int n_checks = 0, n_fail = 0;
  // reference: architectural pc, at most one in-flight address to drop, at most one frozen word
  logic [31:0] m_pc = RST_PC;
  logic [31:0] m_stale[$];
  logic [31:0] m_held[$];
  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endfunction
  task automatic cycle(input logic fz, input logic br, input logic [31:0] bt,
                       input logic jp, input logic [31:0] jt, input logic rdy);
    exp_t e;
    logic redir;
    logic [31:0] tgt, rd;
    @(negedge clk);
    rd = $urandom;
    freeze = fz; branch_taken = br; branch_target = bt;
    jump = jp; jump_target = jt; imem_ready = rdy; imem_rdata = rd;
    redir = !fz && (jp || br);
    tgt = jp ? jt : bt;
    e.pcout = m_pc + 32'd4;
    e.req = 1'b1;
    e.addr = m_pc;
    if (m_held.size() > 0) begin
      e.req = 1'b0; e.instr = m_held[0]; e.flush = 2'b00;
    end else if (m_stale.size() > 0) begin
      e.addr = m_stale[0]; e.instr = NOP_INST; e.flush = 2'b11;
    end else begin
      e.instr = rdy ? rd : NOP_INST; e.flush = rdy ? 2'b00 : 2'b11;
    end
    if (redir) e.flush = jp ? 2'b10 : 2'b01;
    exp_q.push_back(e);
    if (m_held.size() > 0) begin
      if (!fz) begin
        void'(m_held.pop_front());
        m_pc = redir ? tgt : m_pc + 32'd4;
      end
    end else if (m_stale.size() > 0) begin
      if (redir) m_pc = tgt;
      if (rdy) void'(m_stale.pop_front());
    end else if (redir) begin
      if (!rdy) m_stale.push_back(m_pc);
      m_pc = tgt;
    end else if (rdy) begin
      if (fz) m_held.push_back(rd);
      else m_pc = m_pc + 32'd4;
    end
  endtask
  task automatic seq(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
  endtask
  task automatic do_reset();
    #3;
    freeze = 1'b0; branch_taken = 1'b0; jump = 1'b0; imem_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_flush", 32'(flush), 32'd3);
    check("rst_instr", instruction, NOP_INST);
    check("rst_pc_out", pc_out, 32'd0);
    @(posedge clk);
    #1;
    check("rst_req_held", 32'(imem_req), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_pc = RST_PC;
    m_stale.delete();
    m_held.delete();
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("imem_req", 32'(imem_req), 32'(e.req));
        if (e.req) check("imem_addr", imem_addr, e.addr);
        check("instruction", instruction, e.instr);
        check("pc_out", pc_out, e.pcout);
        check("flush", 32'(flush), 32'(e.flush));
      end
    end
  end
  initial begin : driver
    do_reset();
    seq(4);
    do_reset();
    seq(2);
    cycle(1'b0, 1'b1, 32'h40, 1'b0, 32'd0, 1'b1);
    seq(2);
    do_reset();
    seq(2);
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 32'h100, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    seq(3);
    do_reset();
    seq(3);
    cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    seq(2);
    cycle(1'b0, 1'b1, 32'h40, 1'b1, 32'h200, 1'b1);
    seq(1);
    cycle(1'b1, 1'b1, 32'h40, 1'b1, 32'h300, 1'b0);
    cycle(1'b1, 1'b1, 32'h40, 1'b1, 32'h300, 1'b1);
    cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    seq(1);
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    seq(3);
    cycle(1'b0, 1'b1, 32'h80, 1'b0, 32'd0, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 32'h120, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    do_reset();
    cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    seq(2);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 249) == 0) do_reset();
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0, $urandom,
            $urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 4) < 3);
    end
    @(negedge clk);
    #5;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
